// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch (read-only) and data ports.
// Latency: req in IDLE cycle T -> one-cycle ack in T+MEM_LATENCY+1; one access per MEM_LATENCY+2 cycles.
// Backpressure: a losing req waits, no ack, until the next IDLE; MEM_ARBITER_ROUND_ROBIN_EN alternates ties.
module mem_arbiter #(
    parameter int  MEM_WIDTH   = 32,
    parameter int  MEM_SIZE    = 256,
    parameter int  MEM_LATENCY = 1,
    localparam int AW          = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [AW-1:0]        if_addr,
    output logic                 if_ack,
    output logic [MEM_WIDTH-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [AW-1:0]        d_addr,
    input  logic [MEM_WIDTH-1:0] d_wdata,
    output logic                 d_ack,
    output logic [MEM_WIDTH-1:0] d_rdata,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    input  logic [MEM_WIDTH-1:0] mem_read_val,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner_d;    // 1: data port owns the current access
    logic       we_q;
    logic       grant_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // On a tie the port that did not win last goes; reset value favours data first.
    logic last_d;

    always_comb grant_d = d_req && (!if_req || !last_d);

    always_ff @(posedge clk) begin
        if (reset)
            last_d <= 1'b0;
        else if (state == IDLE && (d_req || if_req))
            last_d <= grant_d;
    end
`else
    always_comb grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            owner_d       <= 1'b0;
            we_q          <= 1'b0;
            if_ack        <= 1'b0;
            d_ack         <= 1'b0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            mem_addr      <= '0;
            mem_read_en   <= 1'b0;
            mem_write_en  <= 1'b0;
            mem_write_val <= '0;
            busy          <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        state        <= ACCESS;
                        cnt          <= 4'd0;
                        busy         <= 1'b1;
                        owner_d      <= grant_d;
                        we_q         <= grant_d & d_we;
                        mem_addr     <= grant_d ? d_addr : if_addr;
                        mem_read_en  <= ~(grant_d & d_we);
                        mem_write_en <= grant_d & d_we;
                        if (grant_d)
                            mem_write_val <= d_wdata;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        state        <= RESP;
                        cnt          <= 4'd0;
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!we_q)
                                d_rdata <= mem_read_val;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_read_val;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances with MEM_LATENCY = 1, 2, 3 (index = latency), each on its own memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;

    logic        if_req        [1:3];
    logic [7:0]  if_addr       [1:3];
    logic        if_ack        [1:3];
    logic [31:0] if_rdata      [1:3];
    logic        d_req         [1:3];
    logic        d_we          [1:3];
    logic [7:0]  d_addr        [1:3];
    logic [31:0] d_wdata       [1:3];
    logic        d_ack         [1:3];
    logic [31:0] d_rdata       [1:3];
    logic [7:0]  mem_addr      [1:3];
    logic        mem_read_en   [1:3];
    logic        mem_write_en  [1:3];
    logic [31:0] mem_write_val [1:3];
    logic [31:0] mem_read_val  [1:3];
    logic        busy          [1:3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    for (genvar L = 1; L <= 3; L++) begin : g_dut
        logic [31:0] mem [256];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hCAFEF00D;
        end

        assign mem_read_val[L] = mem[mem_addr[L]];

        always @(posedge clk)
            if (mem_write_en[L]) mem[mem_addr[L]] <= mem_write_val[L];

        always @(negedge clk)
            if (!reset) check($sformatf("strobe_excl_L%0d", L),
                              32'(mem_read_en[L] & mem_write_en[L]), 32'd0);

        mem_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256), .MEM_LATENCY(L)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .if_req       (if_req[L]),
            .if_addr      (if_addr[L]),
            .if_ack       (if_ack[L]),
            .if_rdata     (if_rdata[L]),
            .d_req        (d_req[L]),
            .d_we         (d_we[L]),
            .d_addr       (d_addr[L]),
            .d_wdata      (d_wdata[L]),
            .d_ack        (d_ack[L]),
            .d_rdata      (d_rdata[L]),
            .mem_addr     (mem_addr[L]),
            .mem_read_en  (mem_read_en[L]),
            .mem_write_en (mem_write_en[L]),
            .mem_write_val(mem_write_val[L]),
            .mem_read_val (mem_read_val[L]),
            .busy         (busy[L])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input int L, input string tag);
        check({tag, "_if_ack"},   32'(if_ack[L]),       32'd0);
        check({tag, "_d_ack"},    32'(d_ack[L]),        32'd0);
        check({tag, "_if_rdata"}, if_rdata[L],          32'd0);
        check({tag, "_d_rdata"},  d_rdata[L],           32'd0);
        check({tag, "_addr"},     32'(mem_addr[L]),     32'd0);
        check({tag, "_rd_en"},    32'(mem_read_en[L]),  32'd0);
        check({tag, "_wr_en"},    32'(mem_write_en[L]), 32'd0);
        check({tag, "_wval"},     mem_write_val[L],     32'd0);
        check({tag, "_busy"},     32'(busy[L]),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        for (int L = 1; L <= 3; L++) begin
            if_req[L] = 0; if_addr[L] = 0; d_req[L] = 0; d_we[L] = 0;
            d_addr[L] = 0; d_wdata[L] = 0;
        end
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        for (int L = 1; L <= 3; L++) check_idle_outputs(L, $sformatf("rst_L%0d", L));

        // Single fetch, latency 1
        if_req[1] = 1; if_addr[1] = 8'h10;
        tick();
        check("f1_rd_en_T1", 32'(mem_read_en[1]),  32'd1);
        check("f1_addr_T1",  32'(mem_addr[1]),     32'h10);
        check("f1_busy_T1",  32'(busy[1]),         32'd1);
        check("f1_ack_T1",   32'(if_ack[1]),       32'd0);
        tick();
        check("f1_ack_T2",   32'(if_ack[1]),       32'd1);
        check("f1_rdata_T2", if_rdata[1],          32'hDEADBEEF);
        check("f1_rd_en_T2", 32'(mem_read_en[1]),  32'd0);
        check("f1_busy_T2",  32'(busy[1]),         32'd1);
        if_req[1] = 0;
        tick();
        check("f1_ack_T3",   32'(if_ack[1]),       32'd0);
        check("f1_busy_T3",  32'(busy[1]),         32'd0);

        // Write then read, latency 3
        d_req[3] = 1; d_we[3] = 1; d_addr[3] = 8'h20; d_wdata[3] = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("w3_wr_en_T%0d", c), 32'(mem_write_en[3]), 32'd1);
            check($sformatf("w3_rd_en_T%0d", c), 32'(mem_read_en[3]),  32'd0);
            check($sformatf("w3_ack_T%0d", c),   32'(d_ack[3]),        32'd0);
        end
        check("w3_wval", mem_write_val[3], 32'h12345678);
        tick();
        check("w3_ack_T4",    32'(d_ack[3]),        32'd1);
        check("w3_wr_en_T4",  32'(mem_write_en[3]), 32'd0);
        check("w3_rdata_T4",  d_rdata[3],           32'd0);
        d_req[3] = 0;
        tick();
        d_req[3] = 1; d_we[3] = 0;
        tick(); tick(); tick();
        check("r3_ack_T3",    32'(d_ack[3]),        32'd0);
        tick();
        check("r3_ack_T4",    32'(d_ack[3]),        32'd1);
        check("r3_rdata_T4",  d_rdata[3],           32'h12345678);
        d_req[3] = 0;
        tick();

        // Simultaneous requests, latency 1: data first, fetch 3 cycles later
        if_req[1] = 1; if_addr[1] = 8'h30;
        d_req[1] = 1; d_we[1] = 0; d_addr[1] = 8'h20;
        tick();
        check("sim_addr_T1", 32'(mem_addr[1]), 32'h20);
        tick();
        check("sim_d_ack_T2",  32'(d_ack[1]),  32'd1);
        check("sim_if_ack_T2", 32'(if_ack[1]), 32'd0);
        d_req[1] = 0;
        tick();
        check("sim_if_ack_T3", 32'(if_ack[1]), 32'd0);
        tick();
        check("sim_addr_T4",   32'(mem_addr[1]), 32'h30);
        check("sim_if_ack_T4", 32'(if_ack[1]), 32'd0);
        tick();
        check("sim_if_ack_T5", 32'(if_ack[1]), 32'd1);
        check("sim_d_ack_T5",  32'(d_ack[1]),  32'd0);
        check("sim_if_rdata",  if_rdata[1],    32'hCAFEF00D);
        if_req[1] = 0;
        tick();

        // Withdrawn request, latency 2
        d_req[2] = 1; d_we[2] = 0; d_addr[2] = 8'h30;
        tick();
        d_req[2] = 0;
        check("wd_busy_T1", 32'(busy[2]), 32'd1);
        tick();
        check("wd_ack_T2",  32'(d_ack[2]), 32'd0);
        tick();
        check("wd_ack_T3",  32'(d_ack[2]), 32'd1);
        check("wd_rdata",   d_rdata[2],    32'hCAFEF00D);
        tick();
        check("wd_ack_T4",  32'(d_ack[2]), 32'd0);
        tick();
        check("wd_busy_T5", 32'(busy[2]),  32'd0);

        // Reset during second ACCESS cycle, latency 3
        if_req[3] = 1; if_addr[3] = 8'h10;
        tick();
        tick();
        reset = 1;
        tick();
        check_idle_outputs(3, "mid_rst");
        reset = 0; if_req[3] = 0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            acks += int'(if_ack[3]) + int'(d_ack[3]);
        end
        check("mid_rst_no_ack", 32'(acks), 32'd0);
        if_req[3] = 1; if_addr[3] = 8'h10;
        tick(); tick(); tick();
        check("post_rst_ack_T3", 32'(if_ack[3]), 32'd0);
        tick();
        check("post_rst_ack_T4", 32'(if_ack[3]), 32'd1);
        check("post_rst_rdata",  if_rdata[3],    32'hDEADBEEF);
        if_req[3] = 0;
        tick();

        // Back-to-back fetches with req held, latency 1
        if_req[1] = 1; if_addr[1] = 8'h10;
        tick(); tick();
        check("b2b_ack_T2",   32'(if_ack[1]),      32'd1);
        tick();
        check("b2b_busy_T3",  32'(busy[1]),        32'd0);
        check("b2b_rd_en_T3", 32'(mem_read_en[1]), 32'd0);
        tick();
        check("b2b_rd_en_T4", 32'(mem_read_en[1]), 32'd1);
        check("b2b_ack_T4",   32'(if_ack[1]),      32'd0);
        tick();
        check("b2b_ack_T5",   32'(if_ack[1]),      32'd1);
        if_req[1] = 0;
        tick();
        check("b2b_ack_T6",   32'(if_ack[1]),      32'd0);
        tick();
        check("b2b_busy_T7",  32'(busy[1]),        32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
